ov7670_pixel_fifo: RTL

- Rate-decoupling pixel buffer between the OV7670 capture controller (newPixel strobe plus 16-bit RGB565 pixelData) and the ILI9341 display driver.
- Absorbs camera burstiness per line.
- Aligns pixels to frame boundaries on frameStart.
- Presents a first-word-fall-through pixel stream with a running frame address (pixelAddr) to the driver, replacing the full-frame RAM.
- Single clock domain; the upstream stage delivers newPixel and frameStart already synchronised to CLK_I.

---
 rtl/ov7670_pixel_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ov7670_pixel_fifo.sv
// ============================================================================
// ov7670_pixel_fifo : frame-aligned FWFT pixel buffer, camera -> display
// Rev 1.0
// ============================================================================
`default_nettype none

module ov7670_pixel_fifo #(
  parameter int DEPTH        = 512,
  parameter int ADDR_W       = 9,
  parameter int FRAME_PIXELS = 76800,
  parameter int PIX_ADDR_W   = 17
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  newPixel,
  input  logic [15:0]           pixelData,
  input  logic                  frameStart,
  input  logic                  pixelReq,
  output logic [15:0]           pixelDataOut,
  output logic                  pixelValid,
  output logic [PIX_ADDR_W-1:0] pixelAddr,
  output logic                  frameDone,
  output logic                  overflow,
  output logic [ADDR_W:0]       level
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [ADDR_W:0]       C_FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [PIX_ADDR_W:0]   C_FRAME_CNT = (PIX_ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [PIX_ADDR_W-1:0] C_LAST_ADDR = PIX_ADDR_W'(FRAME_PIXELS - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]       level_q, level_d;
  logic [PIX_ADDR_W:0]   wcnt_q, wcnt_d;
  logic [PIX_ADDR_W-1:0] addr_q, addr_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  sel_q, sel_d;
  logic [15:0]           byp_q, byp_d;

  logic [15:0]           mem [DEPTH];
  logic [15:0]           ram_q;
  logic [ADDR_W-1:0]     w_wr_addr, w_rd_addr;
  logic                  w_in_stream, w_pop, w_wr, w_drop, w_bypass;

  // State register
  always_ff @(posedge CLK_I) begin
    if (RST_I) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (frameStart)
      state_d = S_STREAM;
    else if (state_q == S_STREAM && wcnt_d == C_FRAME_CNT)
      state_d = S_HOLD;
  end

  // FSM outputs: write acceptance and overflow decisions
  always_comb begin
    w_in_stream = (state_q == S_STREAM);
    w_pop       = pixelReq && (level_q != '0) && !frameStart;
    w_wr        = newPixel && (frameStart ||
                  (w_in_stream && (level_q != C_FULL_LVL || w_pop)));
    w_drop      = newPixel && !frameStart && w_in_stream &&
                  (level_q == C_FULL_LVL) && !w_pop;
  end

  // The head lives in the RAM read register, except when the pixel being
  // written becomes the head at once; then it is captured in byp_q.
  always_comb begin
    w_bypass  = w_wr && (frameStart || level_q == '0 ||
                         (w_pop && level_q == (ADDR_W+1)'(1)));
    w_wr_addr = frameStart ? '0 : wptr_q;
    w_rd_addr = rptr_q + ADDR_W'(w_pop);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    sel_d   = sel_q;
    byp_d   = byp_q;

    if (frameStart) begin
      wptr_d  = ADDR_W'(w_wr);
      rptr_d  = '0;
      level_d = (ADDR_W+1)'(w_wr);
      wcnt_d  = (PIX_ADDR_W+1)'(w_wr);
      addr_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      wptr_d = wptr_q + ADDR_W'(w_wr);
      rptr_d = rptr_q + ADDR_W'(w_pop);
      wcnt_d = wcnt_q + (PIX_ADDR_W+1)'(w_wr);
      unique case ({w_wr, w_pop})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
      if (w_pop) begin
        addr_d = (addr_q == C_LAST_ADDR) ? '0 : addr_q + PIX_ADDR_W'(1);
        done_d = (addr_q == C_LAST_ADDR);
      end
      ovf_d = ovf_q | w_drop;
    end

    if (w_bypass) begin
      sel_d = 1'b1;
      byp_d = pixelData;
    end else if (w_pop) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (w_wr) mem[w_wr_addr] <= pixelData;
    ram_q <= mem[w_rd_addr];
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b1;
      byp_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      byp_q   <= byp_d;
    end
  end

  assign pixelDataOut = sel_q ? byp_q : ram_q;
  assign pixelValid   = (level_q != '0);
  assign pixelAddr    = addr_q;
  assign frameDone    = done_q;
  assign overflow     = ovf_q;
  assign level        = level_q;

endmodule

`default_nettype wire
